// File: rtl/memory_cycle.sv
// memory_cycle: RISC-V memory stage with a multi-cycle request/ready data bus and M/W pipeline register.
//   clk, rst (async, active-low)
//   M-stage in : regwritem, memwritem, resultsrcm, rd_m, pcplus4m, writedatam, alu_resultm
//   bus        : dmem_req, dmem_we, dmem_addr, dmem_wdata (out), dmem_rdata, dmem_ready (in)
//   W-stage out: regwritew, resultsrcw, rd_w, pcplus4w, alu_resultw, readdataw
//   status     : stall_m (combinational), bus_err, align_err (sticky until reset)
module memory_cycle #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwritem,
    input  logic        memwritem,
    input  logic        resultsrcm,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pcplus4m,
    input  logic [31:0] writedatam,
    input  logic [31:0] alu_resultm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        regwritew,
    output logic        resultsrcw,
    output logic [4:0]  rd_w,
    output logic [31:0] pcplus4w,
    output logic [31:0] alu_resultw,
    output logic [31:0] readdataw,
    output logic        stall_m,
    output logic        bus_err,
    output logic        align_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    // Counter value seen in the last permitted BUSY cycle (BUSY cycle number TIMEOUT).
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_h_rw, r_h_rs;
    logic [4:0]  r_h_rd;
    logic [31:0] r_h_pc, r_h_alu;
    logic        w_memop, w_mis, w_accept, w_done, w_tmo;

    always_comb begin
        w_memop  = memwritem | resultsrcm;
        w_mis    = w_memop & (alu_resultm[1:0] != 2'b00);
        w_accept = (r_state == IDLE) & w_memop & ~w_mis;
        w_done   = (r_state == BUSY) & dmem_ready;
        // Ready in the same cycle as the timeout wins, so the timeout requires ~dmem_ready.
        w_tmo    = (r_state == BUSY) & ~dmem_ready & (r_cnt == LAST);
        w_next   = w_accept ? BUSY : (w_done | w_tmo) ? IDLE : r_state;
        // Gated by rst so the freeze request drops the moment reset asserts.
        stall_m  = rst & (w_accept | ((r_state == BUSY) & ~dmem_ready & ~w_tmo));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_h_rw      <= 1'b0;
            r_h_rs      <= 1'b0;
            r_h_rd      <= '0;
            r_h_pc      <= '0;
            r_h_alu     <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            regwritew   <= 1'b0;
            resultsrcw  <= 1'b0;
            rd_w        <= '0;
            pcplus4w    <= '0;
            alu_resultw <= '0;
            readdataw   <= '0;
            bus_err     <= 1'b0;
            align_err   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_h_rw     <= regwritem;
                r_h_rs     <= resultsrcm;
                r_h_rd     <= rd_m;
                r_h_pc     <= pcplus4m;
                r_h_alu    <= alu_resultm;
                dmem_req   <= 1'b1;
                dmem_we    <= memwritem;
                dmem_addr  <= {alu_resultm[31:2], 2'b00};
                dmem_wdata <= writedatam;
                r_cnt      <= '0;
                regwritew  <= 1'b0;
            end else begin
                regwritew   <= regwritem & ~w_mis;
                resultsrcw  <= resultsrcm;
                rd_w        <= rd_m;
                pcplus4w    <= pcplus4m;
                alu_resultw <= alu_resultm;
                if (w_mis) align_err <= 1'b1;
            end
        end else begin
            r_cnt <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
            if (w_done | w_tmo) begin
                dmem_req    <= 1'b0;
                regwritew   <= r_h_rw & dmem_ready;
                resultsrcw  <= r_h_rs;
                rd_w        <= r_h_rd;
                pcplus4w    <= r_h_pc;
                alu_resultw <= r_h_alu;
                if (w_done & ~dmem_we) readdataw <= dmem_rdata;
                if (w_tmo) bus_err <= 1'b1;
            end else begin
                regwritew <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed bench for memory_cycle with a transaction-level reference model.
module tb_memory_cycle;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regwritem = 0, memwritem = 0, resultsrcm = 0;
    logic [4:0]  rd_m = '0;
    logic [31:0] pcplus4m = '0, writedatam = '0, alu_resultm = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ready = 1'b0;
    logic        regwritew, resultsrcw;
    logic [4:0]  rd_w;
    logic [31:0] pcplus4w, alu_resultw, readdataw;
    logic        stall_m, bus_err, align_err;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .regwritem(regwritem), .memwritem(memwritem), .resultsrcm(resultsrcm),
        .rd_m(rd_m), .pcplus4m(pcplus4m), .writedatam(writedatam), .alu_resultm(alu_resultm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .regwritew(regwritew), .resultsrcw(resultsrcw), .rd_w(rd_w),
        .pcplus4w(pcplus4w), .alu_resultw(alu_resultw), .readdataw(readdataw),
        .stall_m(stall_m), .bus_err(bus_err), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction record plus the BUSY cycles it has spent.
    logic        busy;
    int          age;
    logic        h_rw, h_rs, h_store;
    logic [4:0]  h_rd;
    logic [31:0] h_pc, h_alu;
    logic        e_req, e_we, e_rw, e_rs, e_berr, e_aerr, e_wload;
    logic [4:0]  e_rd;
    logic [31:0] e_addr, e_wdata, e_pc, e_alu, e_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 0; age <= 0; h_rw <= 0; h_rs <= 0; h_store <= 0; h_rd <= 0; h_pc <= 0; h_alu <= 0;
            e_req <= 0; e_we <= 0; e_rw <= 0; e_rs <= 0; e_berr <= 0; e_aerr <= 0; e_wload <= 0;
            e_rd <= 0; e_addr <= 0; e_wdata <= 0; e_pc <= 0; e_alu <= 0; e_rdata <= 0;
        end else if (!busy) begin
            if ((memwritem || resultsrcm) && alu_resultm[1:0] == 2'b00) begin
                busy <= 1; age <= 0;
                h_rw <= regwritem; h_rs <= resultsrcm; h_rd <= rd_m; h_pc <= pcplus4m;
                h_alu <= alu_resultm; h_store <= memwritem;
                e_req <= 1; e_we <= memwritem; e_addr <= alu_resultm; e_wdata <= writedatam;
                e_rw <= 0; e_wload <= 0;
            end else begin
                e_rw <= regwritem && !(memwritem || resultsrcm);
                e_rs <= resultsrcm; e_rd <= rd_m; e_pc <= pcplus4m; e_alu <= alu_resultm;
                e_wload <= 1;
                if (memwritem || resultsrcm) e_aerr <= 1;
            end
        end else if (dmem_ready || age + 1 == TMO) begin
            busy <= 0; e_req <= 0;
            e_rw <= dmem_ready && h_rw;
            e_rs <= h_rs; e_rd <= h_rd; e_pc <= h_pc; e_alu <= h_alu; e_wload <= 1;
            if (dmem_ready && !h_store) e_rdata <= dmem_rdata;
            if (!dmem_ready) e_berr <= 1;
        end else begin
            age <= age + 1; e_rw <= 0; e_wload <= 0;
        end
    end

    logic es;
    always @(negedge clk) begin
        if (rst) begin
            es = !busy ? ((memwritem || resultsrcm) && alu_resultm[1:0] == 2'b00)
                       : (!dmem_ready && age + 1 < TMO);
            chk("stall_m", stall_m, es);
            chk("dmem_req", dmem_req, e_req);
            chk("regwritew", regwritew, e_rw);
            chk("readdataw", readdataw, e_rdata);
            chk("bus_err", bus_err, e_berr);
            chk("align_err", align_err, e_aerr);
            if (e_req) begin
                chk("dmem_we", dmem_we, e_we);
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (e_wload) begin
                chk("resultsrcw", resultsrcw, e_rs);
                chk("rd_w", rd_w, e_rd);
                chk("pcplus4w", pcplus4w, e_pc);
                chk("alu_resultw", alu_resultw, e_alu);
            end
        end
    end

    // Length of the current or most recent dmem_req pulse, in cycles.
    int run = 0;
    int pulse_len = 0;
    always @(negedge clk) begin
        if (dmem_req) begin
            run++;
            pulse_len = run;
        end else run = 0;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic rw, input logic ws, input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
        regwritem = rw; memwritem = ws; resultsrcm = rs; rd_m = rd;
        pcplus4m = pc; writedatam = wd; alu_resultm = alu;
    endtask

    initial begin
        #3 rst = 0;
        #1;
        chk("reset dmem_req", dmem_req, 0);
        chk("reset regwritew", regwritew, 0);
        chk("reset readdataw", readdataw, 0);
        chk("reset stall_m", stall_m, 0);
        chk("reset bus_err", bus_err, 0);
        chk("reset align_err", align_err, 0);
        step;
        rst = 1;

        // ALU pass-through
        drv(1, 0, 0, 5, 32'h14, 32'h0, 32'h40);
        #1 chk("pass stall_m", stall_m, 0);
        step;
        chk("pass regwritew", regwritew, 1);
        chk("pass rd_w", rd_w, 5);
        chk("pass alu_resultw", alu_resultw, 32'h40);
        chk("pass dmem_req", dmem_req, 0);

        // Load, ready in BUSY cycle 3
        drv(1, 0, 1, 7, 32'h18, 32'h0, 32'h100);
        #1 chk("load accept stall_m", stall_m, 1);
        step;
        chk("load dmem_req", dmem_req, 1);
        chk("load dmem_we", dmem_we, 0);
        chk("load regwritew bubble", regwritew, 0);
        step;
        step;
        dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
        #1 chk("load ready stall_m", stall_m, 0);
        step;
        dmem_ready = 0; dmem_rdata = 32'h0;
        // Zero-wait store issued back-to-back
        drv(0, 1, 0, 0, 32'h1C, 32'h12345678, 32'h200);
        #1;
        chk("load readdataw", readdataw, 32'hDEADBEEF);
        chk("load regwritew", regwritew, 1);
        chk("load rd_w", rd_w, 7);
        chk("load req pulse", pulse_len, 3);
        chk("load done dmem_req", dmem_req, 0);
        chk("store accept stall_m", stall_m, 1);
        step;
        chk("store dmem_we", dmem_we, 1);
        chk("store dmem_addr", dmem_addr, 32'h200);
        chk("store dmem_wdata", dmem_wdata, 32'h12345678);
        dmem_ready = 1;
        step;
        dmem_ready = 0;
        drv(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("store regwritew", regwritew, 0);
        chk("store readdataw", readdataw, 32'hDEADBEEF);
        chk("store req pulse", pulse_len, 1);

        // Timeout
        drv(1, 0, 1, 9, 32'h20, 32'h0, 32'h300);
        step;
        step;
        step;
        step;
        #1 chk("timeout stall_m", stall_m, 0);
        step;
        drv(1, 0, 0, 3, 32'h24, 32'h0, 32'h55);
        #1;
        chk("timeout bus_err", bus_err, 1);
        chk("timeout regwritew", regwritew, 0);
        chk("timeout req pulse", pulse_len, 4);
        chk("timeout dmem_req", dmem_req, 0);
        step;
        chk("after tmo regwritew", regwritew, 1);
        chk("after tmo rd_w", rd_w, 3);
        chk("after tmo bus_err", bus_err, 1);

        // Misaligned load
        drv(1, 0, 1, 4, 32'h28, 32'h0, 32'h102);
        #1 chk("mis stall_m", stall_m, 0);
        step;
        drv(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("mis dmem_req", dmem_req, 0);
        chk("mis align_err", align_err, 1);
        chk("mis regwritew", regwritew, 0);

        // Reset mid-access
        drv(1, 0, 1, 6, 32'h2C, 32'h0, 32'h400);
        step;
        step;
        #2 rst = 0;
        #1;
        chk("rst dmem_req", dmem_req, 0);
        chk("rst stall_m", stall_m, 0);
        chk("rst regwritew", regwritew, 0);
        chk("rst rd_w", rd_w, 0);
        chk("rst alu_resultw", alu_resultw, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst align_err", align_err, 0);
        drv(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        step;
        rst = 1;
        step;
        dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
        step;
        dmem_ready = 0;
        #1;
        chk("stray readdataw", readdataw, 0);
        chk("stray dmem_req", dmem_req, 0);
        chk("stray stall_m", stall_m, 0);
        step;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the five-stage RISC-V pipeline. It consumes the M-stage register outputs of the execute stage, performs loads and stores over a request/ready data-memory bus that may take several cycles, and registers the M/W pipeline boundary for writeback. While a bus access is outstanding it asserts `stall_m` so the hazard unit freezes F/D/E and the E/M register. It also flags misaligned word accesses and bus timeouts.

## Interface
- `TIMEOUT`, 16: maximum cycles in BUSY before abort; legal range 2..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `regwritem` in 1: M-stage register-write enable.
- `memwritem` in 1: M-stage store.
- `resultsrcm` in 1: M-stage load (result from memory).
- `rd_m` in 5: M-stage destination register.
- `pcplus4m` in 32: M-stage PC+4.
- `writedatam` in 32: store data.
- `alu_resultm` in 32: effective address / ALU result.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 32: word address; bits [1:0] are always 0.
- `dmem_wdata` out 32: write data.
- `dmem_rdata` in 32: read data, valid while `dmem_ready` is 1.
- `dmem_ready` in 1: one-cycle completion strobe from memory.
- `regwritew`, `resultsrcw` out 1: W-stage controls.
- `rd_w` out 5; `pcplus4w`, `alu_resultw`, `readdataw` out 32: W-stage data.
- `stall_m` out 1: combinational freeze request to the hazard unit.
- `bus_err` out 1: sticky timeout flag.
- `align_err` out 1: sticky misalignment flag.

## Operation
- memop = `memwritem | resultsrcm`. If both are 1, treat the access as a store; `resultsrcw` still follows the input.
- The FSM has two states, IDLE and BUSY.
- **IDLE, no memop:**
  - W registers load the M inputs.
  - `readdataw` holds its previous value.
  - `stall_m` = 0.
- **IDLE, memop, `alu_resultm[1:0]` != 0:**
  - No bus request; `align_err` is set to 1.
  - W registers load the M inputs with `regwritew` forced to 0.
  - `stall_m` = 0.
- **IDLE, memop, aligned:**
  - Capture `regwritem`, `resultsrcm`, `rd_m`, `pcplus4m`, `alu_resultm` into holding registers.
  - Register `dmem_req`=1, `dmem_we`=`memwritem`, `dmem_addr`=`alu_resultm`, `dmem_wdata`=`writedatam`.
  - Clear the cycle counter, go to BUSY.
  - `stall_m` = 1. W receives a bubble (`regwritew`=0).
- **BUSY:**
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` stay stable. The M inputs are ignored.
  - The counter increments by 1 each cycle and saturates.
  - `stall_m` = `~dmem_ready`.
- **BUSY with `dmem_ready`=1:**
  - `dmem_req` goes to 0; go to IDLE.
  - W loads the holding registers. `readdataw` loads `dmem_rdata` on a read and holds its value on a write.
- **BUSY, no ready, counter = `TIMEOUT`-1:**
  - `dmem_req` goes to 0 and `bus_err` is set to 1; go to IDLE.
  - W loads the holding registers with `regwritew` forced to 0.
  - `stall_m` = 0 in this cycle.
- `dmem_ready` and timeout in the same cycle: ready wins and no error is raised.
- `dmem_ready` while in IDLE is ignored.
- `bus_err` and `align_err` clear only on reset.

## Timing
- All outputs are 0 on reset (`rst`=0), asynchronously, including the error flags; state returns to IDLE.
- Reset during BUSY drops `dmem_req` at once. Any in-flight access is abandoned.
- Non-memory instruction: 1-cycle latency, M to W.
- Aligned access: `dmem_req` rises on the edge after IDLE acceptance.
- Ready in BUSY cycle k (k = 1 is the first BUSY cycle) puts W valid after the edge ending that cycle. `stall_m` is high for k cycles, so the minimum is 2 cycles of total M occupancy.
- Timeout: `dmem_req` is high for exactly `TIMEOUT` cycles.
- The next memop may be accepted in the IDLE cycle immediately after completion. This gives back-to-back requests with one `dmem_req`=0 cycle between them.
- `stall_m` is combinational from state, memop, `alu_resultm[1:0]` and `dmem_ready`.

## Test plan
- **ALU pass-through:** reset, then `regwritem`=1, `rd_m`=5, `alu_resultm`=0x00000040, no memop -> next cycle `regwritew`=1, `rd_w`=5, `alu_resultw`=0x40, `stall_m` stays 0, `dmem_req` stays 0.
- **Load with 3-cycle latency:** `resultsrcm`=1, `alu_resultm`=0x100, ready in BUSY cycle 3 with `dmem_rdata`=0xDEADBEEF -> `dmem_req` high 3 cycles, `dmem_we`=0, `stall_m` high 3 cycles, then `readdataw`=0xDEADBEEF and `regwritew`=1.
- **Zero-wait store:** `memwritem`=1, `writedatam`=0x12345678, `alu_resultm`=0x200, ready in BUSY cycle 1 -> `dmem_we`=1, `dmem_addr`=0x200, `dmem_wdata`=0x12345678, `regwritew`=0, `readdataw` unchanged.
- **Timeout:** `TIMEOUT`=4, load with ready never asserted -> `dmem_req` high exactly 4 cycles, then `bus_err`=1 persists, `regwritew`=0, next instruction proceeds normally.
- **Misaligned load:** `resultsrcm`=1, `alu_resultm`=0x102 -> no `dmem_req`, `align_err`=1, `stall_m`=0, `regwritew`=0.
- **Reset mid-access:** pull `rst` low during BUSY cycle 2 -> `dmem_req`, `stall_m` and all W outputs go to 0 immediately; after release the FSM is in IDLE and a stray `dmem_ready` is ignored.
